// File: rtl/cp0_pkg.sv
// Shared constants and types for coprocessor 0: register numbers, ExcCodes,
// the Status reset value and the exception-source bit positions.
package cp0_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned EXC_W  = 5;
   localparam int unsigned SIG_W  = 4;

   localparam logic [REG_W-1:0] REG_STATUS = 5'd12;
   localparam logic [REG_W-1:0] REG_CAUSE  = 5'd13;
   localparam logic [REG_W-1:0] REG_EPC    = 5'd14;

   localparam logic [EXC_W-1:0] EXC_INT    = 5'd0;
   localparam logic [EXC_W-1:0] EXC_SYS    = 5'd8;
   localparam logic [EXC_W-1:0] EXC_UNIMPL = 5'd10;
   localparam logic [EXC_W-1:0] EXC_OVF    = 5'd12;

   localparam logic [DATA_W-1:0] STATUS_RST = 32'h0000_000F;

   localparam int unsigned SIG_INT    = 0;
   localparam int unsigned SIG_SYS    = 1;
   localparam int unsigned SIG_UNIMPL = 2;
   localparam int unsigned SIG_OVF    = 3;

   typedef struct packed {
      logic             valid;
      logic [EXC_W-1:0] code;
   } exc_t;

endpackage

// File: rtl/cp0_exc_encoder.sv
// Priority encoder from exception sources to an ExcCode: Ovf > Unimpl > Sys > INT.
module cp0_exc_encoder
   import cp0_pkg::*;
(
   input  logic [SIG_W-1:0] signal_i,
   output exc_t             exc_c
);

   always_comb begin
      exc_c.valid = |signal_i;
      exc_c.code  = EXC_INT;
      if (signal_i[SIG_OVF])         exc_c.code = EXC_OVF;
      else if (signal_i[SIG_UNIMPL]) exc_c.code = EXC_UNIMPL;
      else if (signal_i[SIG_SYS])    exc_c.code = EXC_SYS;
      else                           exc_c.code = EXC_INT;
   end

endmodule

// File: rtl/cp0.sv
// Coprocessor 0: Status/Cause/EPC with exception entry, eret, mtc0 and mfc0.
// Optional WB-to-ID write bypass on CPRD when CP0_BYPASS_EN is defined.
module cp0
   import cp0_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [SIG_W-1:0]  Signal,
   input  logic [REG_W-1:0]  CPRA,
   input  logic              CPWr,
   input  logic [2:0]        PCSrc,
   input  logic [DATA_W-1:0] CPWD,
   input  logic [DATA_W-1:0] EPCIn,
   input  logic [REG_W-1:0]  CPWA,
   output logic [DATA_W-1:0] CPRD,
   output logic [DATA_W-1:0] EPCOut,
   output logic [DATA_W-1:0] StatusOut,
   output logic [DATA_W-1:0] CauseOut,
   input  logic              PCWr,
   input  logic              EPCWr,
   input  logic              eret
);

   logic [DATA_W-1:0] status_q, status_d;
   logic [DATA_W-1:0] epc_q, epc_d;
   logic [EXC_W-1:0]  exc_q, exc_d;
   logic              entry_c;
   exc_t              exc_c;
   logic              unused_pcsrc;

   assign unused_pcsrc = ^PCSrc;

   cp0_exc_encoder u_enc (
      .signal_i (Signal),
      .exc_c    (exc_c)
   );

   assign entry_c = EPCWr & PCWr;

   // Exception entry wins outright; otherwise mtc0 applies, then eret restores enables.
   always_comb begin
      status_d = status_q;
      epc_d    = epc_q;
      exc_d    = exc_q;
      if (entry_c) begin
         epc_d         = EPCIn;
         status_d[7:4] = status_q[3:0];
         status_d[3:0] = 4'b0000;
         if (exc_c.valid) exc_d = exc_c.code;
      end else begin
         if (CPWr) begin
            case (CPWA)
               REG_STATUS: status_d = CPWD;
               REG_EPC:    epc_d    = CPWD;
               default:    ;
            endcase
         end
         if (eret) status_d[3:0] = status_q[7:4];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         status_q <= STATUS_RST;
         epc_q    <= '0;
         exc_q    <= EXC_INT;
      end else begin
         status_q <= status_d;
         epc_q    <= epc_d;
         exc_q    <= exc_d;
      end
   end

   assign StatusOut = status_q;
   assign EPCOut    = epc_q;
   assign CauseOut  = {25'b0, exc_q, 2'b00};

   always_comb begin
      CPRD = '0;
      case (CPRA)
         REG_STATUS: CPRD = StatusOut;
         REG_CAUSE:  CPRD = CauseOut;
         REG_EPC:    CPRD = EPCOut;
         default:    CPRD = '0;
      endcase
`ifdef CP0_BYPASS_EN
      if (CPWr && (CPWA == CPRA) && ((CPWA == REG_STATUS) || (CPWA == REG_EPC)))
         CPRD = CPWD;
`endif
   end

endmodule

// File: tb/tb_cp0.sv
// Table-driven bench for cp0: each record drives one cycle, checks CPRD before
// the edge and the three registers after it.
module tb_cp0;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  Signal;
   logic [4:0]  CPRA;
   logic        CPWr;
   logic [2:0]  PCSrc;
   logic [31:0] CPWD;
   logic [31:0] EPCIn;
   logic [4:0]  CPWA;
   logic [31:0] CPRD;
   logic [31:0] EPCOut;
   logic [31:0] StatusOut;
   logic [31:0] CauseOut;
   logic        PCWr;
   logic        EPCWr;
   logic        eret;

`ifdef CP0_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   always #5 clk = ~clk;

   cp0 dut (
      .clk(clk), .rst(rst), .Signal(Signal), .CPRA(CPRA), .CPWr(CPWr),
      .PCSrc(PCSrc), .CPWD(CPWD), .EPCIn(EPCIn), .CPWA(CPWA), .CPRD(CPRD),
      .EPCOut(EPCOut), .StatusOut(StatusOut), .CauseOut(CauseOut),
      .PCWr(PCWr), .EPCWr(EPCWr), .eret(eret)
   );

   typedef struct {
      logic [3:0]  sig;
      logic        epcwr;
      logic        pcwr;
      logic [31:0] epcin;
      logic        eret;
      logic        cpwr;
      logic [4:0]  cpwa;
      logic [31:0] cpwd;
      logic [4:0]  cpra;
      logic [31:0] exp_rd;
      logic [31:0] exp_st;
      logic [31:0] exp_ca;
      logic [31:0] exp_epc;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic add(input logic [3:0] sig, input logic epcwr, input logic pcwr,
                      input logic [31:0] epcin, input logic er, input logic cpwr,
                      input logic [4:0] cpwa, input logic [31:0] cpwd, input logic [4:0] cpra,
                      input logic [31:0] rd, input logic [31:0] st, input logic [31:0] ca,
                      input logic [31:0] ep);
      vec_t v;
      v.sig = sig; v.epcwr = epcwr; v.pcwr = pcwr; v.epcin = epcin; v.eret = er;
      v.cpwr = cpwr; v.cpwa = cpwa; v.cpwd = cpwd; v.cpra = cpra;
      v.exp_rd = rd; v.exp_st = st; v.exp_ca = ca; v.exp_epc = ep;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic idle();
      Signal = '0; EPCWr = 0; PCWr = 0; EPCIn = '0; eret = 0;
      CPWr = 0; CPWA = '0; CPWD = '0; CPRA = '0;
   endtask

   task automatic check_regs(input int idx, input logic [31:0] st, input logic [31:0] ca,
                             input logic [31:0] ep);
      chk("status", idx, StatusOut, st);
      chk("cause",  idx, CauseOut,  ca);
      chk("epc",    idx, EPCOut,    ep);
   endtask

   initial begin
      // sig epcwr pcwr epcin eret cpwr cpwa cpwd cpra | rd status cause epc
      add(4'b0000,0,0,32'h0,  0,0,5'd0, 32'h0,12, 32'h0F, 32'h0F, 32'h00, 32'h0);
      add(4'b0000,0,0,32'h0,  0,0,5'd0, 32'h0,13, 32'h00, 32'h0F, 32'h00, 32'h0);
      add(4'b0000,0,0,32'h0,  0,0,5'd0, 32'h0,14, 32'h00, 32'h0F, 32'h00, 32'h0);
      add(4'b0000,0,0,32'h0,  0,0,5'd0, 32'h0, 0, 32'h00, 32'h0F, 32'h00, 32'h0);
      // Ovf+INT entry -> ExcCode 12
      add(4'b1001,1,1,32'h40, 0,0,5'd0, 32'h0,12, 32'h0F, 32'hF0, 32'h30, 32'h40);
      add(4'b0000,0,0,32'h0,  1,0,5'd0, 32'h0,14, 32'h40, 32'hFF, 32'h30, 32'h40);
      // entry request without PCWr has no effect
      add(4'b1000,1,0,32'h99, 0,0,5'd0, 32'h0,13, 32'h30, 32'hFF, 32'h30, 32'h40);
      // Cause is read-only
      add(4'b0000,0,0,32'h0,  0,1,5'd13,32'hFFFF_FFFF,13, 32'h30, 32'hFF, 32'h30, 32'h40);
      // Sys entry beats same-cycle mtc0 to EPC
      add(4'b0010,1,1,32'h200,0,1,5'd14,32'h1234,12, 32'hFF, 32'hF0, 32'h20, 32'h200);
      // entry with no source: ExcCode kept, EPC/Status still update
      add(4'b0000,1,1,32'h300,0,0,5'd0, 32'h0,14, 32'h200, 32'h00, 32'h20, 32'h300);
      // Unimpl beats Sys+INT; eret dropped
      add(4'b0111,1,1,32'h304,1,0,5'd0, 32'h0,14, 32'h300, 32'h00, 32'h28, 32'h304);
      add(4'b0000,0,0,32'h0,  0,1,5'd14,32'hBFC0_0180,13, 32'h28, 32'h00, 32'h28, 32'hBFC0_0180);
      add(4'b0000,0,0,32'h0,  0,1,5'd12,32'h0000_FF0A,12, BYP ? 32'hFF0A : 32'h00,
          32'hFF0A, 32'h28, 32'hBFC0_0180);
      // mtc0 Status with eret: eret restores [3:0] from saved enables
      add(4'b0000,0,0,32'h0,  1,1,5'd12,32'h5500_0005, 0, 32'h00, 32'h5500_0000, 32'h28, 32'hBFC0_0180);
      // INT entry -> ExcCode 0
      add(4'b0001,1,1,32'h10, 0,0,5'd0, 32'h0,13, 32'h28, 32'h5500_0000, 32'h00, 32'h10);
      add(4'b0000,0,0,32'h0,  0,1,5'd12,32'hA5, 12, BYP ? 32'hA5 : 32'h5500_0000,
          32'hA5, 32'h00, 32'h10);
      // write to an unimplemented register: ignored, read of it is zero
      add(4'b0000,0,0,32'h0,  0,1,5'd5, 32'h1, 5, 32'h00, 32'hA5, 32'h00, 32'h10);
      add(4'b0000,0,0,32'h0,  0,1,5'd14,32'h77, 14, BYP ? 32'h77 : 32'h10,
          32'hA5, 32'h00, 32'h77);

      idle();
      PCSrc = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_vec++;
      check_regs(-1, 32'h0F, 32'h00, 32'h0);

      foreach (vecs[i]) begin
         @(negedge clk);
         Signal = vecs[i].sig; EPCWr = vecs[i].epcwr; PCWr = vecs[i].pcwr;
         EPCIn = vecs[i].epcin; eret = vecs[i].eret; CPWr = vecs[i].cpwr;
         CPWA = vecs[i].cpwa; CPWD = vecs[i].cpwd; CPRA = vecs[i].cpra;
         PCSrc = 3'(i);
         #1;
         n_vec++;
         chk("cprd", i, CPRD, vecs[i].exp_rd);
         @(posedge clk);
         #1;
         check_regs(i, vecs[i].exp_st, vecs[i].exp_ca, vecs[i].exp_epc);
      end

      // Reset mid-handler: take an exception, then reset while a new entry is requested
      @(negedge clk);
      idle();
      Signal = 4'b1000; EPCWr = 1; PCWr = 1; EPCIn = 32'hDEAD_0000;
      @(posedge clk); #1;
      n_vec++;
      check_regs(100, 32'h50, 32'h30, 32'hDEAD_0000);
      @(negedge clk);
      rst = 1'b1; Signal = 4'b0010; EPCIn = 32'h1111_0000; eret = 1; CPWr = 1;
      CPWA = 5'd12; CPWD = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      n_vec++;
      check_regs(101, 32'h0F, 32'h00, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      idle();
      // eret after reset: saved enables are gone, so Status[3:0] clears
      eret = 1;
      @(posedge clk); #1;
      n_vec++;
      check_regs(102, 32'h00, 32'h00, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
